// File: rtl/mem_byte_arbiter_pkg.sv
// Shared definitions for the byte-wide memory arbiter: load/store size codes,
// FSM state encoding and the start of the IO-mapped address window.
package mem_byte_arbiter_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [31:0] IO_BASE_ADDR = 32'h0003_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

    // Index of the last byte of an access; size 2'b11 behaves like a word.
    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (size)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            SZ_W:    return 2'd3;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto a byte-wide memory
// port, splitting each access into single-byte reads or writes.
module mem_byte_arbiter
    import mem_byte_arbiter_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = IO_BASE_ADDR,
    parameter int          IF_BYTES = 4,
    parameter bit          LS_FIRST = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam logic [1:0] IF_LAST = 2'(IF_BYTES - 1);

    arb_state_t  state_q, state_d;
    logic        cur_if_q;
    logic [1:0]  last_q;
    logic [1:0]  wr_idx_q;
    logic [2:0]  cnt_q;
    logic [23:0] gather_q;
    logic [23:0] wbuf_q;
    logic        mem_wr_q;

    logic        pick_ls, pick_if, accept, read_last, wr_finish;
    logic [31:0] wr_next_addr, gathered, read_word;

    // A stalled or paused cycle must never write, even though the register holds.
    assign mem_wr = mem_wr_q & rdy_in;

    always_comb begin
        pick_ls      = ls_req && (LS_FIRST || !if_req);
        pick_if      = if_req && !pick_ls;
        accept       = (state_q == ST_IDLE) && !if_done && !ls_done && (pick_ls || pick_if);
        read_last    = cnt_q == ({1'b0, last_q} + 3'd1);
        wr_finish    = mem_wr_q && (wr_idx_q == last_q);
        wr_next_addr = mem_wr_q ? mem_a + 32'd1 : mem_a;
        gathered     = {mem_din, gather_q};
        read_word    = gathered >> {2'd3 - last_q, 3'b000};
        state_d      = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (pick_ls && ls_wr) ? ST_WRITE : ST_READ;
            ST_READ:  if (read_last) state_d = ST_IDLE;
            ST_WRITE: if (wr_finish) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)      state_q <= ST_IDLE;
        else if (rdy_in) state_q <= state_d;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cur_if_q <= 1'b0;
            last_q   <= 2'd0;
            wr_idx_q <= 2'd0;
            cnt_q    <= 3'd0;
            gather_q <= 24'd0;
            wbuf_q   <= 24'd0;
            mem_wr_q <= 1'b0;
            mem_a    <= 32'd0;
            mem_dout <= 8'd0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= 32'd0;
            ls_rdata <= 32'd0;
        end else if (rdy_in) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cur_if_q <= !pick_ls;
                        last_q   <= pick_ls ? size_last(ls_size) : IF_LAST;
                        wr_idx_q <= 2'd0;
                        cnt_q    <= 3'd0;
                        mem_a    <= pick_ls ? ls_addr : if_addr;
                        mem_dout <= ls_wdata[7:0];
                        wbuf_q   <= ls_wdata[31:8];
                        mem_wr_q <= pick_ls && ls_wr && !(io_buffer_full && ls_addr >= IO_BASE);
                    end
                end
                // Bytes arrive two edges after their address; the last one goes
                // straight into the result without passing through gather_q.
                ST_READ: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q < {1'b0, last_q}) mem_a <= mem_a + 32'd1;
                    if (read_last) begin
                        if (cur_if_q) begin
                            if_data <= read_word;
                            if_done <= 1'b1;
                        end else begin
                            ls_rdata <= read_word;
                            ls_done  <= 1'b1;
                        end
                    end else if (cnt_q != 3'd0) begin
                        gather_q <= {mem_din, gather_q[23:8]};
                    end
                end
                // mem_wr_q low means the current byte is still pending after an IO stall.
                ST_WRITE: begin
                    if (wr_finish) begin
                        mem_wr_q <= 1'b0;
                        ls_done  <= 1'b1;
                    end else begin
                        if (mem_wr_q) begin
                            mem_a    <= mem_a + 32'd1;
                            mem_dout <= wbuf_q[7:0];
                            wbuf_q   <= {8'h00, wbuf_q[23:8]};
                            wr_idx_q <= wr_idx_q + 2'd1;
                        end
                        mem_wr_q <= !(io_buffer_full && wr_next_addr >= IO_BASE);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_arbiter.sv
// Directed bench for mem_byte_arbiter: a byte RAM model plus scoreboards of
// expected completions and expected memory writes.
module tb_mem_byte_arbiter;
    import mem_byte_arbiter_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n, rdy_in, if_req, ls_req, ls_wr, io_buffer_full;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_size;
    logic [7:0]  mem_din;
    logic        if_done, ls_done, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [7:0]  mem_dout;

    typedef struct {
        bit          is_if;
        bit          chk_data;
        logic [31:0] data;
        string       tag;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    logic [31:0] addr_hist[$];
    bit   [7:0]  ram [0:262143];

    int vectors     = 0;
    int miscompares = 0;
    int done_at, writes;

    mem_byte_arbiter dut (
        .clk_in(clk_in), .rst_n(rst_n), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous byte RAM, paused together with the core while rdy_in is low.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) ram[mem_a[17:0]] = mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drives one request and records what the bench expects from it.
    task automatic applyStimulus(input bit use_if, input bit wr, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expdata, input string tag);
        exp_t e;
        int   n;
        logic [31:0] d;
        e.is_if = use_if; e.chk_data = !wr; e.data = expdata; e.tag = tag;
        exp_q.push_back(e);
        if (use_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
            if (wr) begin
                n = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
                d = wdata;
                for (int k = 0; k < n; k++) begin
                    wr_q.push_back({addr + 32'(k), d[7:0]});
                    d = d >> 8;
                end
            end
        end
    endtask

    task automatic runUntilDone(input int ndone, input int budget, input int full_off_at,
                                input int rdy_lo_at, input int rdy_lo_len,
                                output int last_done_at, output int writes_seen);
        int   seen = 0;
        int   i = 0;
        exp_t e;
        wr_t  w;
        last_done_at = 0; writes_seen = 0;
        addr_hist.delete();
        while (seen < ndone && i < budget) begin
            @(negedge clk_in);
            i++;
            addr_hist.push_back(mem_a);
            if (mem_wr) begin
                writes_seen++;
                if (wr_q.size() == 0) checkOutput("unexpected_wr", {31'd0, mem_wr}, 32'd0);
                else begin
                    w = wr_q.pop_front();
                    checkOutput("wr_addr", mem_a, w.addr);
                    checkOutput("wr_data", {24'd0, mem_dout}, {24'd0, w.data});
                end
            end
            if (if_done || ls_done) begin
                seen++;
                last_done_at = i;
                checkOutput("done_excl", {31'd0, if_done & ls_done}, 32'd0);
                if (exp_q.size() == 0) checkOutput("unexpected_done", {30'd0, if_done, ls_done}, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    checkOutput({e.tag, "_port"}, {30'd0, if_done, ls_done}, e.is_if ? 32'd2 : 32'd1);
                    if (e.chk_data) checkOutput({e.tag, "_data"}, e.is_if ? if_data : ls_rdata, e.data);
                end
                if (if_done) if_req = 1'b0;
                if (ls_done) ls_req = 1'b0;
            end
            if (i == full_off_at) io_buffer_full = 1'b0;
            rdy_in = !(i >= rdy_lo_at && i < rdy_lo_at + rdy_lo_len);
        end
        if (seen < ndone) checkOutput("timeout", seen, ndone);
    endtask

    initial begin
        rst_n = 1'b0; rdy_in = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
        io_buffer_full = 1'b0; if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_size = SZ_B;
        ram[18'h01000] = 8'h13; ram[18'h01001] = 8'h00; ram[18'h01002] = 8'h50; ram[18'h01003] = 8'h00;
        ram[18'h02003] = 8'hF0; ram[18'h3FFFF] = 8'h77; ram[18'h00000] = 8'h66;
        repeat (2) @(negedge clk_in);
        checkOutput("rst_mem_a", mem_a, 32'd0);
        checkOutput("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
        checkOutput("rst_if_data", if_data, 32'd0);
        checkOutput("rst_ls_rdata", ls_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Word fetch: one address per cycle, done five edges after acceptance.
        applyStimulus(1'b1, 1'b0, SZ_W, 32'h1000, 32'd0, 32'h0050_0013, "fetch");
        runUntilDone(1, 20, 0, 0, 0, done_at, writes);
        checkOutput("fetch_latency", done_at, 6);
        for (int k = 0; k < 4; k++) checkOutput("fetch_addr", addr_hist[k], 32'h1000 + 32'(k));
        checkOutput("fetch_addr_hold", addr_hist[4], 32'h1003);
        @(negedge clk_in);

        // LS wins the tie; IF is accepted once the LS done cycle has passed.
        applyStimulus(1'b0, 1'b0, SZ_B, 32'h2003, 32'd0, 32'h0000_00F0, "tie_ls");
        applyStimulus(1'b1, 1'b0, SZ_W, 32'h1000, 32'd0, 32'h0050_0013, "tie_if");
        runUntilDone(2, 30, 0, 0, 0, done_at, writes);
        checkOutput("tie_if_latency", done_at, 10);
        @(negedge clk_in);

        applyStimulus(1'b0, 1'b1, SZ_W, 32'h0FFE, 32'hDEAD_BEEF, 32'd0, "st_word");
        runUntilDone(1, 20, 0, 0, 0, done_at, writes);
        checkOutput("st_word_writes", writes, 4);
        checkOutput("st_word_latency", done_at, 5);
        @(negedge clk_in);

        applyStimulus(1'b0, 1'b0, SZ_W, 32'h0FFE, 32'd0, 32'hDEAD_BEEF, "ld_misaligned");
        runUntilDone(1, 20, 0, 0, 0, done_at, writes);
        checkOutput("ld_misaligned_latency", done_at, 6);
        @(negedge clk_in);

        // Half load across the top of the address space wraps to zero.
        applyStimulus(1'b0, 1'b0, SZ_H, 32'hFFFF_FFFF, 32'd0, 32'h0000_6677, "ld_wrap");
        runUntilDone(1, 20, 0, 0, 0, done_at, writes);
        checkOutput("ld_wrap_latency", done_at, 4);
        checkOutput("ld_wrap_addr0", addr_hist[0], 32'hFFFF_FFFF);
        checkOutput("ld_wrap_addr1", addr_hist[1], 32'h0000_0000);
        @(negedge clk_in);

        io_buffer_full = 1'b1;
        applyStimulus(1'b0, 1'b1, SZ_B, 32'h0003_0000, 32'h0000_0041, 32'd0, "st_io");
        runUntilDone(1, 20, 3, 0, 0, done_at, writes);
        checkOutput("st_io_writes", writes, 1);
        checkOutput("st_io_latency", done_at, 5);
        @(negedge clk_in);

        io_buffer_full = 1'b1;
        applyStimulus(1'b0, 1'b1, SZ_B, 32'h0002_FFFF, 32'h0000_005A, 32'd0, "st_ram_full");
        runUntilDone(1, 20, 99, 0, 0, done_at, writes);
        checkOutput("st_ram_full_writes", writes, 1);
        checkOutput("st_ram_full_latency", done_at, 2);
        io_buffer_full = 1'b0;
        @(negedge clk_in);

        // Two paused cycles in the middle of a fetch push completion out by two.
        applyStimulus(1'b1, 1'b0, SZ_W, 32'h1000, 32'd0, 32'h0050_DEAD, "fetch_pause");
        runUntilDone(1, 20, 0, 2, 2, done_at, writes);
        checkOutput("fetch_pause_latency", done_at, 8);
        rdy_in = 1'b1;
        @(negedge clk_in);

        // Reset in the middle of a store clears every output at once.
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = SZ_W; ls_addr = 32'h0500; ls_wdata = 32'h1122_3344;
        @(negedge clk_in);
        checkOutput("rst_st_wr0", {31'd0, mem_wr}, 32'd1);
        checkOutput("rst_st_a0", mem_a, 32'h0500);
        checkOutput("rst_st_d0", {24'd0, mem_dout}, 32'h44);
        @(negedge clk_in);
        checkOutput("rst_st_a1", mem_a, 32'h0501);
        checkOutput("rst_st_d1", {24'd0, mem_dout}, 32'h33);
        rst_n = 1'b0;
        ls_req = 1'b0;
        #1;
        checkOutput("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("midrst_mem_a", mem_a, 32'd0);
        checkOutput("midrst_mem_dout", {24'd0, mem_dout}, 32'd0);
        checkOutput("midrst_if_data", if_data, 32'd0);
        checkOutput("midrst_ls_rdata", ls_rdata, 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        applyStimulus(1'b0, 1'b0, SZ_B, 32'h0FFF, 32'd0, 32'h0000_00BE, "after_rst");
        runUntilDone(1, 20, 0, 0, 0, done_at, writes);
        checkOutput("after_rst_latency", done_at, 3);
        checkOutput("after_rst_writes", writes, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
